// File: rtl/rf_par_freq_drv.sv
// rtl/rf_par_freq_drv.sv - parallel synthesiser-code writer fed by the RF control top's frequency output
//
// Turns each frequency request into code = floor(freq/10), range-checks it and
// writes it to the RF module's parallel port as setup / latch-enable / hold.
// A single pending slot absorbs requests that arrive during a write (latest wins).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_rf_freq        16-bit requested frequency, valid with i_rf_freq_ctrl
//   i_rf_freq_ctrl   one-cycle request strobe
//   i_stop           level; aborts the current write and blocks requests
//   o_par_data       10-bit code driven to the RF module
//   o_par_le         latch enable, active high
//   o_busy           request captured and write not yet finished
//   o_done           pulse in the final hold cycle of a completed write
//   o_range_err      pulse when a captured code is outside CODE_MIN..CODE_MAX
//   o_overrun        pulse when a request replaces a still-pending one
//   o_wr_cnt         completed-write counter, wraps
module rf_par_freq_drv #(
    parameter int SETUP_CYC  = 20,
    parameter int STROBE_CYC = 10,
    parameter int HOLD_CYC   = 20,
    parameter int CODE_MIN   = 0,
    parameter int CODE_MAX   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_rf_freq,
    input  logic        i_rf_freq_ctrl,
    input  logic        i_stop,
    output logic [9:0]  o_par_data,
    output logic        o_par_le,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_range_err,
    output logic        o_overrun,
    output logic [31:0] o_wr_cnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CALC   = 3'd1;
    localparam logic [2:0] SETUP  = 3'd2;
    localparam logic [2:0] STROBE = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;

    logic [2:0]  state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        slot_full;
    logic [15:0] slot_freq;
    logic [9:0]  code_reg;
    logic        err_reg;

    logic [15:0] cap_freq;
    logic [15:0] cap_quo;
    logic        cap_in_range;
    logic        capture;
    logic        final_hold_nxt;

    // A full pending slot always wins over a fresh strobe in IDLE.
    assign cap_freq = slot_full ? slot_freq : i_rf_freq;
    assign cap_quo  = cap_freq / 16'd10;
    // Lower bound written as quo+1 > MIN so a zero minimum stays a real compare.
    assign cap_in_range = (({1'b0, cap_quo} + 17'd1) > 17'(CODE_MIN)) &&
                          (cap_quo <= 16'(CODE_MAX));

    assign capture = !i_stop && (state == IDLE) && (slot_full || i_rf_freq_ctrl);
    assign o_busy  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (i_stop) begin
            state_nxt = IDLE;
            cnt_nxt   = 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = 32'd0;
                    if (capture) state_nxt = CALC;
                end
                CALC: begin
                    cnt_nxt   = 32'd0;
                    state_nxt = err_reg ? IDLE : SETUP;
                end
                SETUP: begin
                    if (cnt == 32'(SETUP_CYC - 1)) begin
                        state_nxt = STROBE;
                        cnt_nxt   = 32'd0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 32'(STROBE_CYC - 1)) begin
                        state_nxt = HOLD;
                        cnt_nxt   = 32'd0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 32'(HOLD_CYC - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 32'd0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 32'd0;
                end
            endcase
        end
    end

    // o_done and the counter are registered from the next state so they are
    // visible during the final hold cycle itself.
    assign final_hold_nxt = (state_nxt == HOLD) && (cnt_nxt == 32'(HOLD_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            slot_full   <= 1'b0;
            slot_freq   <= 16'd0;
            code_reg    <= 10'd0;
            err_reg     <= 1'b0;
            o_par_data  <= 10'd0;
            o_par_le    <= 1'b0;
            o_done      <= 1'b0;
            o_range_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_wr_cnt    <= 32'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            o_par_le    <= (state_nxt == STROBE);
            o_done      <= final_hold_nxt;
            o_range_err <= 1'b0;
            o_overrun   <= 1'b0;

            if (final_hold_nxt) o_wr_cnt <= o_wr_cnt + 32'd1;

            // Code and range flag are settled at capture so the error pulse
            // lands in the CALC cycle.
            if (capture) begin
                code_reg    <= cap_quo[9:0];
                err_reg     <= !cap_in_range;
                o_range_err <= !cap_in_range;
            end

            if (!i_stop && state == CALC && !err_reg) o_par_data <= code_reg;

            if (i_stop) begin
                slot_full <= 1'b0;
            end else if (state == IDLE) begin
                // Slot drained this cycle; a coincident strobe refills it.
                if (slot_full) begin
                    slot_full <= i_rf_freq_ctrl;
                    if (i_rf_freq_ctrl) slot_freq <= i_rf_freq;
                end
            end else if (i_rf_freq_ctrl) begin
                slot_freq <= i_rf_freq;
                slot_full <= 1'b1;
                o_overrun <= slot_full;
            end
        end
    end

endmodule
